lcd_write_engine: RTL and testbench
===================================

// Module: lcd_write_engine
// PURPOSE
//  Physical-side consumer of the RS/RW/DATA byte stream emitted by the mode display blocks. It runs the
//  character-LCD power-up init and generates E strobes with setup/hold/execution timing.
//  It throttles upstream through a valid/ready handshake, one byte per write cycle.
//  Sits between the mode output mux and the LCD pins.
// PARAMETERS
//  PWRUP_WAIT  15000  CLK cycles held idle after reset before the first init command
//  E_HIGH      2      CLK cycles LCD_E stays high per write (>=1)
//  BYTE_WAIT   40     execution wait, CLK cycles, after normal command/data write
//  CLR_WAIT    1600   execution wait after clear (0x01) or home (0x02/0x03) command
// PORTS
//  CLK       in   1  system clock
//  RESET     in   1  asynchronous, active-low reset
//  IN_VALID  in   1  upstream byte valid
//  IN_RS     in   1  0=command, 1=character data
//  IN_RW     in   1  1=idle filler; accepted but not written to LCD
//  IN_DATA   in   8  command/character byte
//  IN_READY  out  1  engine can accept a byte this cycle
//  BUSY      out  1  high during power-up wait and init sequence
//  LCD_E     out  1  LCD enable strobe
//  LCD_RS    out  1  LCD register select
//  LCD_RW    out  1  LCD read/write (always 0 when driven)
//  LCD_DATA  out  8  LCD data bus
//  RD_IDX    in   5  shadow readback index (0-15 line1, 16-31 line2)
//  RD_CHAR   out  8  shadow character at RD_IDX, 1-cycle latency
// BEHAVIOUR
//  - Reset: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, IN_READY=0, BUSY=1, RD_CHAR=0x20, FSM=PWRUP.
//    RESET low at any time aborts any write immediately; E drops asynchronously, and the engine restarts
//    the full init.
//  - FSM: PWRUP -> INIT(issue) -> SETUP -> EHIGH -> HOLD -> WAIT -> (next INIT | IDLE).
//  - PWRUP: counts PWRUP_WAIT cycles. It then issues the init list 0x38, 0x0C, 0x06, 0x01 in that order,
//    all with RS=0. Each init write uses the same SETUP/EHIGH/HOLD/WAIT path.
//  - BUSY falls on the same edge the FSM enters IDLE after the 0x01 wait. IN_READY rises on that same edge.
//  - Handshake: a transfer occurs on a posedge with IN_VALID=1 and IN_READY=1. IN_READY is 1 only in IDLE
//    and is registered low on the accepting edge. Upstream must hold fields stable while IN_VALID=1 and
//    IN_READY=0.
//  - Accepted byte with IN_RW=1: dropped. IN_READY stays high, so back-to-back fillers are absorbed
//    one per cycle.
//  - Accepted byte with IN_RW=0 (acceptance edge k):
//    - Edge k: LCD_RS/LCD_DATA are loaded, LCD_RW=0, LCD_E=0 (SETUP, 1 cycle).
//    - Edge k+1: LCD_E=1 for E_HIGH cycles.
//    - Edge k+1+E_HIGH: LCD_E=0 and the bus is held (HOLD, 1 cycle).
//    - WAIT then lasts W cycles. W=CLR_WAIT if RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise W=BYTE_WAIT.
//    - IN_READY returns 1 at edge k+2+E_HIGH+W.
//  - LCD_RS/LCD_DATA keep the last written value between writes. They never change while LCD_E=1.
//  - Counters are sized by $clog2 of the largest parameter + 1, with no wrap-around. A zero wait skips the
//    WAIT state.
// CONFIGURATION
//  SHADOW_RAM_EN defined:
//    - A 32-byte shadow buffer plus a DDRAM address register are maintained from the LCD writes actually
//      issued, including init writes.
//    - Command 0x80|a sets addr=a.
//    - Command 0x01 fills the buffer with 0x20 and sets addr=0.
//    - A data write stores at index addr (0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31; other addresses are not
//      stored), then addr increments modulo 128.
//    - RD_CHAR is registered from buffer[RD_IDX].
//    - The buffer resets to 0x20 and addr resets to 0.
//  SHADOW_RAM_EN undefined: no buffer; RD_CHAR is constant 0x20 and RD_IDX is ignored.
// TESTING  (bench params: PWRUP_WAIT=20, E_HIGH=2, BYTE_WAIT=5, CLR_WAIT=30)
//  1. Release reset, IN_VALID=0 -> after 20 cycles, four E pulses with DATA 0x38, 0x0C, 0x06, 0x01
//     (RS=0), each 2 cycles wide. Gaps are 5, 5, 5 and then 30 cycles; BUSY=0 and IN_READY=1 afterwards.
//  2. Send RS=1, RW=0, DATA=0x54 -> LCD_DATA=0x54 one cycle before E rises and E is high 2 cycles.
//     IN_READY returns exactly 9 cycles after acceptance.
//  3. Present 8 consecutive RW=1 fillers -> all 8 accepted in 8 cycles, no E pulse, bus unchanged.
//  4. Send command 0x01 -> IN_READY stays low 34 cycles after acceptance, vs 9 cycles for command 0x80.
//  5. Drive RESET low while LCD_E=1 mid-write -> LCD_E=0 immediately, BUSY=1; the full init replays.
//  6. (SHADOW_RAM_EN) Send 0xC3 cmd, then data 0x32, 0x30 -> RD_IDX=19 reads 0x32, RD_IDX=20 reads 0x30,
//     RD_IDX=0 reads 0x20.

Source files
------------

// File: rtl/lcd_write_engine_if.sv
// lcd_write_engine_if: upstream RS/RW/DATA byte-stream handshake into the LCD write engine.
interface lcd_write_engine_if;
    logic       IN_VALID;
    logic       IN_RS;
    logic       IN_RW;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    modport master (output IN_VALID, IN_RS, IN_RW, IN_DATA, input IN_READY);
    modport slave  (input IN_VALID, IN_RS, IN_RW, IN_DATA, output IN_READY);
endinterface

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: character-LCD power-up init plus E-strobe write timing for an upstream byte stream.
// Optional SHADOW_RAM_EN keeps a 32-byte readback shadow of the two visible display lines.
module lcd_write_engine #(
    parameter int PWRUP_WAIT = 15000,
    parameter int E_HIGH     = 2,
    parameter int BYTE_WAIT  = 40,
    parameter int CLR_WAIT   = 1600
) (
    input  logic              CLK,
    input  logic              RESET,
    lcd_write_engine_if.slave up,
    output logic              BUSY,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic [7:0]        LCD_DATA,
    input  logic [4:0]        RD_IDX,
    output logic [7:0]        RD_CHAR
);
    localparam int M0 = PWRUP_WAIT > E_HIGH ? PWRUP_WAIT : E_HIGH;
    localparam int M1 = BYTE_WAIT > CLR_WAIT ? BYTE_WAIT : CLR_WAIT;
    localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EHIGH, HOLD, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          e_q, e_d, rs_q, rs_d, ready_q, ready_d, busy_q, busy_d;
    logic [7:0]    data_q, data_d, init_byte;
    logic [31:0]   cnt_n, wait_len;
    logic          done;

    assign cnt_n     = 32'(cnt_q) + 32'd1;
    assign init_byte = idx_q == 2'd0 ? 8'h38 : idx_q == 2'd1 ? 8'h0C : idx_q == 2'd2 ? 8'h06 : 8'h01;
    // Clear and home need the long execution wait; judged from the byte still on the bus.
    assign wait_len  = (!rs_q && data_q[7:2] == 6'd0 && data_q[1:0] != 2'd0) ? 32'(CLR_WAIT) : 32'(BYTE_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done    = 1'b0;
        case (state_q)
            PWRUP: begin
                cnt_d   = cnt_n >= 32'(PWRUP_WAIT) ? '0 : cnt_q + 1'b1;
                state_d = cnt_n >= 32'(PWRUP_WAIT) ? INIT : PWRUP;
            end
            INIT: begin
                state_d = SETUP;
                rs_d    = 1'b0;
                data_d  = init_byte;
            end
            IDLE: if (up.IN_VALID && !up.IN_RW) begin
                state_d = SETUP;
                rs_d    = up.IN_RS;
                data_d  = up.IN_DATA;
                ready_d = 1'b0;
            end
            SETUP: begin
                state_d = EHIGH;
                e_d     = 1'b1;
                cnt_d   = '0;
            end
            EHIGH: if (cnt_n >= 32'(E_HIGH)) begin
                state_d = HOLD;
                e_d     = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
            HOLD: begin
                cnt_d   = '0;
                state_d = WAIT;
                done    = wait_len == 32'd0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                done  = cnt_n >= wait_len;
            end
            default: state_d = PWRUP;
        endcase
        if (done) begin
            state_d = busy_q && idx_q != 2'd3 ? INIT : IDLE;
            idx_d   = busy_q && idx_q != 2'd3 ? idx_q + 1'b1 : idx_q;
            busy_d  = busy_q && idx_q != 2'd3;
            ready_d = !(busy_q && idx_q != 2'd3);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign up.IN_READY = ready_q;
    assign BUSY        = busy_q;
    assign LCD_E       = e_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = 1'b0;
    assign LCD_DATA    = data_q;

`ifdef SHADOW_RAM_EN
    logic [7:0] shadow_q [32];
    logic [6:0] addr_q;
    logic [7:0] rd_q;
    logic       wr;

    // A write counts as issued on the E falling edge.
    assign wr = state_q == EHIGH && state_d == HOLD;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
            addr_q <= '0;
            rd_q   <= 8'h20;
        end else begin
            rd_q <= shadow_q[RD_IDX];
            if (wr && rs_q) begin
                if (addr_q[6:4] == 3'd0) shadow_q[{1'b0, addr_q[3:0]}] <= data_q;
                else if (addr_q[6:4] == 3'd4) shadow_q[{1'b1, addr_q[3:0]}] <= data_q;
                addr_q <= addr_q + 1'b1;
            end else if (wr && data_q[7]) addr_q <= data_q[6:0];
            else if (wr && data_q == 8'h01) begin
                for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
                addr_q <= '0;
            end
        end
    end

    assign RD_CHAR = rd_q;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^RD_IDX;
    assign RD_CHAR       = 8'h20;
`endif
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: directed checks of init sequence, write timing, fillers, clear wait, abort and shadow readback.
module tb_lcd_write_engine;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BUSY, LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA, RD_CHAR;
    logic [4:0] RD_IDX = '0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    lcd_write_engine_if up();

    lcd_write_engine #(.PWRUP_WAIT(20), .E_HIGH(2), .BYTE_WAIT(5), .CLR_WAIT(30)) dut (
        .CLK(CLK), .RESET(RESET), .up(up), .BUSY(BUSY), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA), .RD_IDX(RD_IDX), .RD_CHAR(RD_CHAR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_lvl(input bit rdy, input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((rdy ? up.IN_READY : LCD_E) !== lvl && n < 400);
        if ((rdy ? up.IN_READY : LCD_E) !== lvl) n = -1;
    endtask

    task automatic init_seq(input string tag);
        int n;
        for (int i = 0; i < 4; i++) begin
            wait_lvl(1'b0, 1'b1, n);
            chk($sformatf("%s e_rise%0d", tag, i), n, i == 0 ? 22 : 8);
            chk($sformatf("%s data%0d", tag, i), LCD_DATA, init_bytes[i]);
            chk($sformatf("%s rs%0d", tag, i), LCD_RS, 0);
            chk($sformatf("%s busy%0d", tag, i), BUSY, 1);
            wait_lvl(1'b0, 1'b0, n);
            chk($sformatf("%s e_width%0d", tag, i), n, 2);
        end
        wait_lvl(1'b1, 1'b1, n);
        chk($sformatf("%s clr_wait", tag), n, 31);
        chk($sformatf("%s busy_done", tag), BUSY, 0);
    endtask

    task automatic xfer(input logic rs, input logic [7:0] d, output int lat, output int erise,
                        output int ehi, output logic [7:0] d0);
        up.IN_VALID = 1'b1;
        up.IN_RS    = rs;
        up.IN_RW    = 1'b0;
        up.IN_DATA  = d;
        @(negedge CLK);
        up.IN_VALID = 1'b0;
        d0    = LCD_DATA;
        lat   = 0;
        erise = -1;
        ehi   = 0;
        while (up.IN_READY !== 1'b1 && lat < 400) begin
            @(negedge CLK);
            lat++;
            if (LCD_E) begin
                ehi++;
                if (erise < 0) erise = lat;
            end
        end
        if (up.IN_READY !== 1'b1) lat = -1;
    endtask

    initial begin
        int lat, erise, ehi, acc;
        logic [7:0] d0;
        up.IN_VALID = 1'b0;
        up.IN_RS    = 1'b0;
        up.IN_RW    = 1'b0;
        up.IN_DATA  = 8'h00;
        @(negedge CLK);
        chk("rst lcd_e", LCD_E, 0);
        chk("rst lcd_rs", LCD_RS, 0);
        chk("rst lcd_rw", LCD_RW, 0);
        chk("rst lcd_data", LCD_DATA, 8'h00);
        chk("rst ready", up.IN_READY, 0);
        chk("rst busy", BUSY, 1);
        chk("rst rd_char", RD_CHAR, 8'h20);
        RESET = 1'b1;
        init_seq("init");

        xfer(1'b1, 8'h54, lat, erise, ehi, d0);
        chk("w54 setup data", d0, 8'h54);
        chk("w54 rs", LCD_RS, 1);
        chk("w54 rw", LCD_RW, 0);
        chk("w54 e_rise", erise, 1);
        chk("w54 e_width", ehi, 2);
        chk("w54 ready_lat", lat, 9);

        acc = 0;
        ehi = 0;
        for (int i = 0; i < 8; i++) begin
            up.IN_VALID = 1'b1;
            up.IN_RW    = 1'b1;
            up.IN_RS    = 1'b0;
            up.IN_DATA  = 8'(8'hA0 + i);
            if (up.IN_READY) acc++;
            @(negedge CLK);
            if (LCD_E) ehi++;
        end
        up.IN_VALID = 1'b0;
        up.IN_RW    = 1'b0;
        chk("fill accepted", acc, 8);
        chk("fill no_e", ehi, 0);
        chk("fill bus data", LCD_DATA, 8'h54);
        chk("fill bus rs", LCD_RS, 1);
        chk("fill ready", up.IN_READY, 1);

        xfer(1'b0, 8'h01, lat, erise, ehi, d0);
        chk("cmd01 ready_lat", lat, 34);
        xfer(1'b0, 8'h80, lat, erise, ehi, d0);
        chk("cmd80 ready_lat", lat, 9);
        xfer(1'b0, 8'h03, lat, erise, ehi, d0);
        chk("cmd03 ready_lat", lat, 34);
        xfer(1'b0, 8'h04, lat, erise, ehi, d0);
        chk("cmd04 ready_lat", lat, 9);
        xfer(1'b1, 8'h01, lat, erise, ehi, d0);
        chk("data01 ready_lat", lat, 9);

        xfer(1'b0, 8'hC3, lat, erise, ehi, d0);
        xfer(1'b1, 8'h32, lat, erise, ehi, d0);
        xfer(1'b1, 8'h30, lat, erise, ehi, d0);
        RD_IDX = 5'd19;
        @(negedge CLK);
`ifdef SHADOW_RAM_EN
        chk("shadow idx19", RD_CHAR, 8'h32);
`else
        chk("shadow idx19", RD_CHAR, 8'h20);
`endif
        RD_IDX = 5'd20;
        @(negedge CLK);
`ifdef SHADOW_RAM_EN
        chk("shadow idx20", RD_CHAR, 8'h30);
`else
        chk("shadow idx20", RD_CHAR, 8'h20);
`endif
        RD_IDX = 5'd0;
        @(negedge CLK);
        chk("shadow idx0", RD_CHAR, 8'h20);

        up.IN_VALID = 1'b1;
        up.IN_RS    = 1'b1;
        up.IN_DATA  = 8'h41;
        @(negedge CLK);
        up.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("abort e_before", LCD_E, 1);
        RESET = 1'b0;
        #1;
        chk("abort e", LCD_E, 0);
        chk("abort busy", BUSY, 1);
        chk("abort ready", up.IN_READY, 0);
        chk("abort data", LCD_DATA, 8'h00);
        @(negedge CLK);
        RESET = 1'b1;
        init_seq("replay");
        RD_IDX = 5'd19;
        @(negedge CLK);
        chk("replay shadow idx19", RD_CHAR, 8'h20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
